// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor with valid/ready flow control.
// The WIDTH-bit datapath is cut into STAGES slices. Slice k is summed in
// pipeline stage k using 4-bit carry-lookahead groups that ripple into each
// other. The slice carry is registered into the next stage. Operand slices
// that are not yet summed ride along in skew registers. Finished sum slices
// ride along in de-skew registers. As a result, every bit of a beat leaves
// the last stage on the same cycle.
module pipe_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int SW = WIDTH / STAGES;  // slice width, a multiple of 4
   localparam int NG = SW / 4;          // carry-lookahead groups per slice
   localparam int L  = STAGES - 1;      // index of the last stage

   // 4-bit carry-lookahead group: returns {carry out, sum[3:0]}
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = x & y;
      p    = x ^ y;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[4], p ^ c[3:0]};
   endfunction

   // One slice: CLA groups with the group carry rippling upward; returns {carry out, sum}
   function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic c0);
      logic [SW-1:0] s;
      logic          c;
      logic [4:0]    grp;
      s = '0;
      c = c0;
      for (int k = 0; k < NG; k++) begin
         grp        = cla4(x[4*k +: 4], y[4*k +: 4], c);
         s[4*k +: 4] = grp[3:0];
         c          = grp[4];
      end
      return {c, s};
   endfunction

   logic               advance;
   logic [STAGES-1:0]  vld_p;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH-1:0]   full_c;

   // Every stage moves together. The pipe stalls only when the output holds
   // a beat that downstream refuses.
   assign advance   = ~vld_p[L] | out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_p[L];
   assign b_eff     = b ^ {WIDTH{sub}};

   // Stage valid bits; an idle input enters as a bubble and shifts with the data
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         vld_p <= '0;
      end else if (advance) begin
         vld_p[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
      end
   end

   // Slice adders: stage i sums slice i from its skewed operands and the registered carry
   for (genvar i = 0; i < STAGES; i++) begin : stg
      logic [SW-1:0] x;
      logic [SW-1:0] y;
      logic          ci;
      logic [SW:0]   r;
      if (i == 0) begin : g_src
         assign x  = a[SW-1:0];
         assign y  = b_eff[SW-1:0];
         assign ci = cin;
      end else begin : g_src
         assign x  = sk[i].st[i-1].a_p;
         assign y  = sk[i].st[i-1].b_p;
         assign ci = cyr[i-1].cy_p;
      end
      assign r = cla_slice(x, y, ci);
   end

   // Inter-stage carries: the carry out of slice i feeds slice i+1 one cycle later
   for (genvar i = 0; i < L; i++) begin : cyr
      logic cy_p;
      // Capture the slice carry for the next stage
      always_ff @(posedge clk or posedge clr) begin
         if (clr)          cy_p <= 1'b0;
         else if (advance) cy_p <= stg[i].r[SW];
      end
   end

   // Skew registers: operand slice j is delayed through stages 0..j-1 until its adder is reached
   for (genvar j = 1; j < STAGES; j++) begin : sk
      for (genvar s = 0; s < j; s++) begin : st
         logic [SW-1:0] a_p;
         logic [SW-1:0] b_p;
         if (s == 0) begin : g_ld
            // Capture the operand slice from the input port
            always_ff @(posedge clk or posedge clr) begin
               if (clr) begin
                  a_p <= '0;
                  b_p <= '0;
               end else if (advance) begin
                  a_p <= a[j*SW +: SW];
                  b_p <= b_eff[j*SW +: SW];
               end
            end
         end else begin : g_ld
            // Pass the operand slice one stage further down
            always_ff @(posedge clk or posedge clr) begin
               if (clr) begin
                  a_p <= '0;
                  b_p <= '0;
               end else if (advance) begin
                  a_p <= sk[j].st[s-1].a_p;
                  b_p <= sk[j].st[s-1].b_p;
               end
            end
         end
      end
   end

   // De-skew registers: finished sum slice j is delayed from stage j up to the last stage
   for (genvar j = 0; j < L; j++) begin : ds
      for (genvar s = j; s < L; s++) begin : st
         logic [SW-1:0] sum_p;
         if (s == j) begin : g_ld
            // Capture the freshly computed sum slice
            always_ff @(posedge clk or posedge clr) begin
               if (clr)          sum_p <= '0;
               else if (advance) sum_p <= stg[j].r[SW-1:0];
            end
         end else begin : g_ld
            // Pass the finished sum slice one stage further down
            always_ff @(posedge clk or posedge clr) begin
               if (clr)          sum_p <= '0;
               else if (advance) sum_p <= ds[j].st[s-1].sum_p;
            end
         end
      end
   end

   // Assemble the complete sum in the last stage: delayed low slices plus the top slice computed now
   for (genvar j = 0; j < L; j++) begin : g_lo
      assign full_c[j*SW +: SW] = ds[j].st[L-1].sum_p;
   end
   assign full_c[L*SW +: SW] = stg[L].r[SW-1:0];

   // Output register: result and flags held steady while the beat waits for out_ready
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
         zero <= 1'b0;
         neg  <= 1'b0;
      end else if (advance) begin
         sum  <= full_c;
         cout <= stg[L].r[SW];
         ovf  <= (stg[L].x[SW-1] == stg[L].y[SW-1]) & (full_c[WIDTH-1] != stg[L].x[SW-1]);
         zero <= ~|full_c;
         neg  <= full_c[WIDTH-1];
      end
   end

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed corner beats, a stall/release case, a
// mid-stream clear, and a long random stream with random back-pressure.
// A queue-based scoreboard checks every beat against an arithmetic model.
module tb_pipe_addsub;
   localparam int WIDTH  = 32;
   localparam int STAGES = 2;

   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic             c;
      logic             v;
      logic             z;
      logic             n;
   } res_t;

   logic             clk = 1'b0;
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;
   logic             neg;

   res_t exp_q[$];
   int   n_vec   = 0;
   int   n_bad   = 0;
   int   n_out   = 0;
   bit   rnd_rdy = 1'b0;

   pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
   );

   always #5 clk = ~clk;

   // Reference: true integer arithmetic, overflow taken from the signed range
   function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic ci, input logic md);
      logic [WIDTH-1:0] yb;
      longint unsigned  tot;
      longint           st;
      longint           lim;
      res_t             r;
      yb  = md ? ~y : y;
      tot = longint'(x) + longint'(yb) + longint'(ci);
      lim = longint'(1) << (WIDTH - 1);
      st  = longint'($signed(x)) + longint'($signed(yb)) + longint'(ci);
      r.s = tot[WIDTH-1:0];
      r.c = tot[WIDTH];
      r.v = (st >= lim) || (st < -lim);
      r.z = (r.s == '0);
      r.n = r.s[WIDTH-1];
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] rand_op();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return {1'b0, {(WIDTH-1){1'b1}}};
         3: return {1'b1, {(WIDTH-1){1'b0}}};
         4: return 32'h0000FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h", nm, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Stimulus side of the scoreboard: an accepted beat pushes its expected result
   always @(negedge clk) begin
      if (!clr && in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
   end

   // Monitor: every emitted beat is popped and compared in order
   always @(negedge clk) begin
      if (!clr && out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_beat: actual sum %h with no beat outstanding", sum);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            check("beat", 64'({sum, cout, ovf, zero, neg}), 64'(e));
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic ci, input logic md);
      in_valid = 1'b1;
      a = x; b = y; cin = ci; sub = md;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            cyc();
            in_valid = 1'b0;
            return;
         end
         cyc();
      end
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: actual in_ready 0 for 200 cycles, required 1");
      in_valid = 1'b0;
   endtask

   task automatic drain();
      rnd_rdy   = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 50; t++) begin
         if (exp_q.size() == 0) break;
         cyc();
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Single beat into an empty pipe: not visible after one edge, visible with req after two
   task automatic lat_check(input string nm, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic ci, input logic md, input logic [WIDTH+3:0] req);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = x; b = y; cin = ci; sub = md;
      @(negedge clk);
      check({nm, "_ready"}, 64'(in_ready), 64'd1);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check({nm, "_early"}, 64'(out_valid), 64'd0);
      cyc();
      @(negedge clk);
      check(nm, 64'({out_valid, sum, cout, ovf, zero, neg}), 64'({1'b1, req}));
      cyc();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: actual run still active, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc;
      int k;
      int n_out0;
      clr = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 64'({out_valid, sum, cout, ovf, zero, neg}), 64'd0);
      clr = 1'b0;
      check("ready_after_reset", 64'(in_ready), 64'd1);

      // Directed corners through the scoreboard
      send(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
      send(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
      send(32'hFFFFFFFF, 32'h1, 1'b1, 1'b0);
      send(32'h5, 32'h5, 1'b1, 1'b1);
      send(32'h3, 32'h5, 1'b1, 1'b1);
      send(32'h0000FFFF, 32'h1, 1'b0, 1'b0);
      drain();

      // Directed corners with literal expectations {sum, cout, ovf, zero, neg}
      lat_check("add_ovf",   32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, {32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1});
      lat_check("add_wrap",  32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, {32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0});
      lat_check("add_cin",   32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, {32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0});
      lat_check("sub_eq",    32'h5,        32'h5, 1'b1, 1'b1, {32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0});
      lat_check("sub_borrow",32'h3,        32'h5, 1'b1, 1'b1, {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1});
      lat_check("slice_cy",  32'h0000FFFF, 32'h1, 1'b0, 1'b0, {32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0});

      // Stall: with out_ready low only two beats fit, the output holds the first
      out_ready = 1'b0;
      acc = 0;
      k   = 1;
      in_valid = 1'b1; a = 32'(k); b = 32'(k); cin = 1'b0; sub = 1'b0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         if (in_ready) begin
            acc++;
            k++;
            cyc();
            a = 32'(k); b = 32'(k);
         end else begin
            cyc();
         end
      end
      @(negedge clk);
      check("stall_accepted", 64'(acc), 64'd2);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_hold", 64'({out_valid, sum}), 64'({1'b1, 32'd2}));
      n_out0 = n_out;
      cyc();
      out_ready = 1'b1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (in_ready) begin
            cyc();
            in_valid = 1'b0;
            break;
         end
         cyc();
      end
      in_valid = 1'b0;
      drain();
      check("release_count", 64'(n_out - n_out0), 64'd3);

      // Clear with two beats in flight
      send(32'd10, 32'd20, 1'b0, 1'b0);
      send(32'd30, 32'd40, 1'b0, 1'b0);
      clr = 1'b1;
      #1;
      check("clr_outputs", 64'({out_valid, sum, cout, ovf, zero, neg}), 64'd0);
      exp_q.delete();
      repeat (2) cyc();
      clr = 1'b0;
      check("clr_in_ready", 64'(in_ready), 64'd1);
      repeat (3) begin
         @(negedge clk);
         check("clr_no_stale", 64'(out_valid), 64'd0);
         cyc();
      end
      lat_check("after_clr", 32'd7, 32'd8, 1'b0, 1'b0, {32'd15, 1'b0, 1'b0, 1'b0, 1'b0});

      // Random stream with bubbles and random back-pressure
      rnd_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            cyc();
         end
         send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
